// File: rtl/clause_queue_pkg.sv
// Shared clause definitions used by the switch and the clause queue.
// Holds the clause payload type plus clause-queue sizing defaults.
// No logic; types and constants only.
package clause_queue_pkg;

  // Clause payload as it travels switch -> queue -> engine.
  typedef struct packed {
    logic [7:0]  id;     // clause identifier
    logic [23:0] body;   // literal / payload bits
  } cla_t;

  localparam int CLQ_DEPTH     = 8;
  localparam int CLQ_AF_MARGIN = 2;

endpackage

// File: rtl/clq_mem.sv
// Clause storage array: synchronous write port, asynchronous read port.
// Read data follows the read address in the same cycle (no read latency).
// No flow control here; the caller decides when writing is legal.
module clq_mem
  import clause_queue_pkg::*;
#(
  parameter int DEPTH = CLQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  cla_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output cla_t          rdata_o
);

  cla_t mem_q [DEPTH];

  // Write the addressed entry; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/clause_queue.sv
// Clause queue between the clause switch and the propagation engine (FWFT FIFO).
// Latency: a written clause is visible at the head one cycle after the write.
// Backpressure: none toward sw; early almost-full throttles upstream, excess writes drop and set sticky overflow.
module clause_queue
  import clause_queue_pkg::*;
#(
  parameter int DEPTH     = CLQ_DEPTH,
  parameter int AF_MARGIN = CLQ_AF_MARGIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  cla_t                     sw2clq,
  input  logic                     sw2clq_valid,
  output logic                     clq2sw_almost_full,
  output logic                     clq2sw_full,
  output cla_t                     clq2eng,
  output logic                     clq2eng_valid,
  input  logic                     eng2clq_ready,
  output logic [$clog2(DEPTH):0]   clq_count,
  output logic                     clq_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Pointer MSB is the wrap bit: equal pointers mean empty, same index with
  // different wrap bits means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop frees a slot in the same cycle, so a full queue can still accept.
  // Flush overrides both so nothing lands in the array during a clear.
  assign pop  = !empty && eng2clq_ready && !flush;
  assign push = sw2clq_valid && (!full || pop) && !flush;
  assign drop = sw2clq_valid && full && !pop && !flush;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + PW'(push) - PW'(pop);
      if (drop) ovf_d = 1'b1;
    end
  end

  // State registers; reset discards all queued clauses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  clq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (sw2clq),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (clq2eng)
  );

  // All outputs come straight from registered state, so neither the write
  // request nor the engine ready reaches them combinationally.
  assign clq2eng_valid      = !empty;
  assign clq2sw_full        = full;
  assign clq2sw_almost_full = (count_q >= AF_THRESH);
  assign clq_count          = count_q;
  assign clq_overflow       = ovf_q;

endmodule

// File: tb/tb_clause_queue.sv
// Randomized and directed bench for clause_queue against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// The model applies the FIFO rules directly on an SV queue.
module tb_clause_queue;
  import clause_queue_pkg::*;

  localparam int D   = 4;
  localparam int AFM = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  cla_t       sw2clq;
  logic       sw2clq_valid;
  logic       eng2clq_ready;
  logic       clq2sw_almost_full;
  logic       clq2sw_full;
  cla_t       clq2eng;
  logic       clq2eng_valid;
  logic [2:0] clq_count;
  logic       clq_overflow;

  clause_queue #(.DEPTH(D), .AF_MARGIN(AFM)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .sw2clq             (sw2clq),
    .sw2clq_valid       (sw2clq_valid),
    .clq2sw_almost_full (clq2sw_almost_full),
    .clq2sw_full        (clq2sw_full),
    .clq2eng            (clq2eng),
    .clq2eng_valid      (clq2eng_valid),
    .eng2clq_ready      (eng2clq_ready),
    .clq_count          (clq_count),
    .clq_overflow       (clq_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] mq[$];
  bit          m_ovf;
  bit          seen70;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_model();
    chk("valid", 32'(clq2eng_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("data", 32'(clq2eng), mq[0]);
    chk("count", 32'(clq_count), 32'(mq.size()));
    chk("full", 32'(clq2sw_full), 32'(mq.size() == D));
    chk("afull", 32'(clq2sw_almost_full), 32'(mq.size() >= D - AFM));
    chk("ovf", 32'(clq_overflow), 32'(m_ovf));
    if (clq2eng_valid && clq2eng == cla_t'(32'd70)) seen70 = 1'b1;
  endtask

  // Check current outputs, advance the model by the rules, then take one edge.
  task automatic step();
    bit p_pop, p_push, is_full;
    @(negedge clk);
    compare_model();
    if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      is_full = (mq.size() == D);
      p_pop   = (mq.size() > 0) && eng2clq_ready;
      p_push  = sw2clq_valid && (!is_full || p_pop);
      if (sw2clq_valid && is_full && !p_pop) m_ovf = 1'b1;
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back(32'(sw2clq));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int d, input bit r, input bit f);
    sw2clq_valid  = v;
    sw2clq        = cla_t'(32'(d));
    eng2clq_ready = r;
    flush         = f;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(clq2eng_valid), 32'd0);
    chk("rst_count", 32'(clq_count), 32'd0);
    chk("rst_full", 32'(clq2sw_full), 32'd0);
    chk("rst_afull", 32'(clq2sw_almost_full), 32'd0);
    chk("rst_ovf", 32'(clq_overflow), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sw2clq = '0; sw2clq_valid = 1'b0; eng2clq_ready = 1'b0;
    m_ovf = 1'b0; seen70 = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // 1: single push, then reset mid-stream.
    drive(1, 5, 0, 0);
    drive(0, 0, 0, 0);
    chk("s1_data", 32'(clq2eng), 32'd5);
    chk("s1_count", 32'(clq_count), 32'd1);
    #2;
    do_reset();

    // 2: fill to almost-full then full.
    drive(1, 5, 0, 0);
    drive(1, 10, 0, 0);
    drive(1, 20, 0, 0);
    chk("s2_count3", 32'(clq_count), 32'd3);
    chk("s2_af", 32'(clq2sw_almost_full), 32'd1);
    drive(1, 30, 0, 0);
    chk("s2_full", 32'(clq2sw_full), 32'd1);

    // 3: overflow while full, then drain.
    drive(1, 50, 0, 0);
    chk("s3_ovf", 32'(clq_overflow), 32'd1);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
    chk("s3_empty", 32'(clq2eng_valid), 32'd0);
    chk("s3_ovf_hold", 32'(clq_overflow), 32'd1);

    // 4: full plus simultaneous push/pop, then drain through the wrap.
    for (int i = 0; i < 4; i++) drive(1, 100 + i, 0, 0);
    drive(1, 60, 1, 0);
    chk("s4_count", 32'(clq_count), 32'd4);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);

    // 5: streaming push with ready held high.
    for (int i = 1; i <= 20; i++) begin
      drive(1, i, 1, 0);
      chk("s5_count_le1", 32'(clq_count <= 1), 32'd1);
    end
    drive(0, 0, 1, 0);

    // 6: three entries with overflow set, flush with a colliding push.
    for (int i = 0; i < 5; i++) drive(1, 200 + i, 0, 0);
    drive(0, 0, 1, 0);
    chk("s6_pre_count", 32'(clq_count), 32'd3);
    chk("s6_pre_ovf", 32'(clq_overflow), 32'd1);
    drive(1, 70, 1, 1);
    chk("s6_count", 32'(clq_count), 32'd0);
    chk("s6_valid", 32'(clq2eng_valid), 32'd0);
    chk("s6_ovf", 32'(clq_overflow), 32'd0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    chk("s6_no70", 32'(seen70), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 60), int'($urandom),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 4));
    end
    drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
